// File: rtl/accum_warp_fetch_coalescer_pkg.sv
// TauCfg: shared configuration constants and the line-table entry type
// for the accumulator warp fetch coalescer.
package TauCfg;

  localparam int unsigned N_ICFG         = 4;
  localparam int unsigned GLOBAL_ADDR_BW = 16;
  localparam int unsigned WORK_BW        = 8;
  localparam int unsigned VDIM           = 2;
  localparam int unsigned LINE_BW        = 5;
  localparam int unsigned LINE_ADDR_BW   = GLOBAL_ADDR_BW - LINE_BW;

  // One table slot: whether a line is remembered, and which line it is.
  typedef struct packed {
    logic                    valid;
    logic [LINE_ADDR_BW-1:0] line;
  } line_entry_t;

  // Saturating 32-bit increment used by the optional statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/accum_warp_fetch_coalescer_line_table.sv
// accum_fetch_line_table: per-config "last line fetched" memory.
// Combinational read port, synchronous write/clear port, synchronous reset
// that invalidates every entry. Out-of-range read indices return an
// invalid entry.
module accum_fetch_line_table
  import TauCfg::*;
#(
  parameter int unsigned N_CFG  = N_ICFG,
  parameter int unsigned IDX_BW = $clog2(N_ICFG + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IDX_BW-1:0]       rd_idx,
  output line_entry_t             rd_entry,
  input  logic                    wr_en,
  input  logic                    wr_clr,
  input  logic [IDX_BW-1:0]       wr_idx,
  input  logic [LINE_ADDR_BW-1:0] wr_line
);

  line_entry_t tbl [N_CFG];

  // Read port: select the addressed entry, invalid if nothing matches.
  always_comb begin
    rd_entry = '0;
    for (int unsigned i = 0; i < N_CFG; i++) begin
      if (rd_idx == IDX_BW'(i)) begin
        rd_entry = tbl[i];
      end
    end
  end

  // Write port: clear on end of sweep, otherwise record the new line.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_CFG; i++) begin
      if (rst) begin
        tbl[i] <= '0;
      end else if (wr_en && (wr_idx == IDX_BW'(i))) begin
        if (wr_clr) begin
          tbl[i].valid <= 1'b0;
        end else begin
          tbl[i].valid <= 1'b1;
          tbl[i].line  <= wr_line;
        end
      end
    end
  end

endmodule

// File: rtl/accum_warp_fetch_coalescer.sv
// accum_warp_fetch_coalescer: splits each warp request's linear address into
// line + in-line offset and flags whether the line must be fetched, based on
// the last line seen for the same config id. Single output register with
// full-throughput valid/ack handshake.
// Optional feature: define ACCUM_FETCH_STAT_EN to add saturating fetch and
// coalesce counters (o_n_fetch, o_n_coalesce).
module accum_warp_fetch_coalescer #(
  parameter  int unsigned N_CFG   = TauCfg::N_ICFG,
  parameter  int unsigned ABW     = TauCfg::GLOBAL_ADDR_BW,
  parameter  int unsigned LINE_BW = TauCfg::LINE_BW,
  parameter  int unsigned WBW     = TauCfg::WORK_BW,
  parameter  int unsigned VDIM    = TauCfg::VDIM,
  localparam int unsigned NCFG_BW = $clog2(N_CFG + 1),
  localparam int unsigned LA_BW   = ABW - LINE_BW
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     src_rdy,
  output logic                     src_ack,
  input  logic [NCFG_BW-1:0]       i_id,
  input  logic [ABW-1:0]           i_linear,
  input  logic [VDIM-1:0][WBW-1:0] i_bofs,
  input  logic                     i_retire,
  input  logic                     i_islast,
  output logic                     dst_rdy,
  input  logic                     dst_ack,
  output logic [NCFG_BW-1:0]       o_id,
  output logic [LA_BW-1:0]         o_line,
  output logic [LINE_BW-1:0]       o_lofs,
  output logic                     o_fetch,
  output logic [VDIM-1:0][WBW-1:0] o_bofs,
  output logic                     o_retire,
  output logic                     o_islast
`ifdef ACCUM_FETCH_STAT_EN
  ,
  output logic [31:0]              o_n_fetch,
  output logic [31:0]              o_n_coalesce
`endif
);

  logic               in_range;
  logic               hit;
  logic               fetch_next;
  logic               tbl_wr_en;
  logic [LA_BW-1:0]   line_in;
  logic [LINE_BW-1:0] lofs_in;
  TauCfg::line_entry_t rd_entry;

  assign line_in = i_linear[ABW-1:LINE_BW];
  assign lofs_in = i_linear[LINE_BW-1:0];

  // Lookup and handshake: ids outside the table always fetch and never touch it.
  always_comb begin
    in_range   = (i_id < NCFG_BW'(N_CFG));
    hit        = in_range & rd_entry.valid & (rd_entry.line == line_in);
    fetch_next = ~hit;
    src_ack    = src_rdy & (~dst_rdy | dst_ack);
    tbl_wr_en  = src_ack & in_range;
  end

  accum_fetch_line_table #(
    .N_CFG  (N_CFG),
    .IDX_BW (NCFG_BW)
  ) u_line_table (
    .clk      (i_clk),
    .rst      (i_rst),
    .rd_idx   (i_id),
    .rd_entry (rd_entry),
    .wr_en    (tbl_wr_en),
    .wr_clr   (i_islast),
    .wr_idx   (i_id),
    .wr_line  (line_in)
  );

  // Output register: load on accept, drop valid once downstream takes it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dst_rdy  <= 1'b0;
      o_id     <= '0;
      o_line   <= '0;
      o_lofs   <= '0;
      o_fetch  <= 1'b0;
      o_bofs   <= '0;
      o_retire <= 1'b0;
      o_islast <= 1'b0;
    end else if (src_ack) begin
      dst_rdy  <= 1'b1;
      o_id     <= i_id;
      o_line   <= line_in;
      o_lofs   <= lofs_in;
      o_fetch  <= fetch_next;
      o_bofs   <= i_bofs;
      o_retire <= i_retire;
      o_islast <= i_islast;
    end else if (dst_ack) begin
      dst_rdy  <= 1'b0;
    end
  end

`ifdef ACCUM_FETCH_STAT_EN
  // Statistics: count accepted requests by fetch/coalesce outcome, saturating.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_n_fetch    <= '0;
      o_n_coalesce <= '0;
    end else if (src_ack) begin
      if (fetch_next) begin
        o_n_fetch <= TauCfg::sat_inc(o_n_fetch);
      end else begin
        o_n_coalesce <= TauCfg::sat_inc(o_n_coalesce);
      end
    end
  end
`endif

endmodule

// File: tb/tb_accum_warp_fetch_coalescer.sv
// Self-checking bench for accum_warp_fetch_coalescer: directed vector table,
// hand-written backpressure/reset sequences, and randomized traffic against
// a queue-based reference model.
module tb_accum_warp_fetch_coalescer;

  localparam int unsigned NCFG  = TauCfg::N_ICFG;
  localparam int unsigned ABW   = TauCfg::GLOBAL_ADDR_BW;
  localparam int unsigned LBW   = TauCfg::LINE_BW;
  localparam int unsigned WBW   = TauCfg::WORK_BW;
  localparam int unsigned VD    = TauCfg::VDIM;
  localparam int unsigned IDW   = $clog2(NCFG + 1);
  localparam int unsigned LAW   = ABW - LBW;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   src_rdy;
  logic                   src_ack;
  logic [IDW-1:0]         i_id;
  logic [ABW-1:0]         i_linear;
  logic [VD-1:0][WBW-1:0] i_bofs;
  logic                   i_retire;
  logic                   i_islast;
  logic                   dst_rdy;
  logic                   dst_ack;
  logic [IDW-1:0]         o_id;
  logic [LAW-1:0]         o_line;
  logic [LBW-1:0]         o_lofs;
  logic                   o_fetch;
  logic [VD-1:0][WBW-1:0] o_bofs;
  logic                   o_retire;
  logic                   o_islast;
`ifdef ACCUM_FETCH_STAT_EN
  logic [31:0]            o_n_fetch;
  logic [31:0]            o_n_coalesce;
`endif

  always #5 clk = ~clk;

  accum_warp_fetch_coalescer dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .src_rdy  (src_rdy),
    .src_ack  (src_ack),
    .i_id     (i_id),
    .i_linear (i_linear),
    .i_bofs   (i_bofs),
    .i_retire (i_retire),
    .i_islast (i_islast),
    .dst_rdy  (dst_rdy),
    .dst_ack  (dst_ack),
    .o_id     (o_id),
    .o_line   (o_line),
    .o_lofs   (o_lofs),
    .o_fetch  (o_fetch),
    .o_bofs   (o_bofs),
    .o_retire (o_retire),
    .o_islast (o_islast)
`ifdef ACCUM_FETCH_STAT_EN
    ,
    .o_n_fetch    (o_n_fetch),
    .o_n_coalesce (o_n_coalesce)
`endif
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    src_rdy  = 1'b0;
    dst_ack  = 1'b0;
    i_id     = '0;
    i_linear = '0;
    i_bofs   = '0;
    i_retire = 1'b0;
    i_islast = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drive(input logic [IDW-1:0] id, input logic [ABW-1:0] lin, input logic last);
    src_rdy  = 1'b1;
    i_id     = id;
    i_linear = lin;
    i_islast = last;
    i_retire = 1'($urandom_range(0, 1));
    i_bofs   = 16'($urandom);
  endtask

  typedef struct {
    logic [IDW-1:0] id;
    logic [ABW-1:0] linear;
    logic           islast;
    logic           fetch;
    logic [LAW-1:0] line;
    logic [LBW-1:0] lofs;
  } vec_t;

  vec_t vecs [12];

  typedef struct {
    logic [IDW-1:0]         id;
    logic [LAW-1:0]         line;
    logic [LBW-1:0]         lofs;
    logic                   fetch;
    logic [VD-1:0][WBW-1:0] bofs;
    logic                   retire;
    logic                   islast;
  } exp_t;

  exp_t            q[$];
  exp_t            e;
  bit              m_valid [8];
  logic [LAW-1:0]  m_line  [8];
  int unsigned     m_nfetch;
  int unsigned     m_ncoal;
  logic            exp_ack;
  logic [VD-1:0][WBW-1:0] held_bofs;
  logic [LAW-1:0]  lin_line;

  initial begin
    // id, linear, islast -> fetch, line, lofs (applied back-to-back after reset)
    vecs[0]  = '{3'd0, 16'h0040, 1'b0, 1'b1, 11'd2, 5'd0};
    vecs[1]  = '{3'd0, 16'h0041, 1'b0, 1'b0, 11'd2, 5'd1};
    vecs[2]  = '{3'd0, 16'h005F, 1'b0, 1'b0, 11'd2, 5'd31};
    vecs[3]  = '{3'd1, 16'h0040, 1'b0, 1'b1, 11'd2, 5'd0};
    vecs[4]  = '{3'd0, 16'h0040, 1'b0, 1'b0, 11'd2, 5'd0};
    vecs[5]  = '{3'd0, 16'h0040, 1'b1, 1'b0, 11'd2, 5'd0};
    vecs[6]  = '{3'd0, 16'h0040, 1'b0, 1'b1, 11'd2, 5'd0};
    vecs[7]  = '{3'd5, 16'h0040, 1'b0, 1'b1, 11'd2, 5'd0};
    vecs[8]  = '{3'd5, 16'h0040, 1'b0, 1'b1, 11'd2, 5'd0};
    vecs[9]  = '{3'd0, 16'h0040, 1'b0, 1'b0, 11'd2, 5'd0};
    vecs[10] = '{3'd2, 16'h0060, 1'b0, 1'b1, 11'd3, 5'd0};
    vecs[11] = '{3'd2, 16'hFFFF, 1'b0, 1'b1, 11'h7FF, 5'd31};

    do_reset();
    check("reset_dst_rdy", 64'(dst_rdy), 64'd0);
    check("reset_fetch",   64'(o_fetch), 64'd0);
    check("reset_line",    64'(o_line),  64'd0);
    check("reset_bofs",    64'(o_bofs),  64'd0);
`ifdef ACCUM_FETCH_STAT_EN
    check("reset_n_fetch", 64'(o_n_fetch), 64'd0);
`endif

    // Directed vectors, one transfer per cycle
    dst_ack = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].id, vecs[i].linear, vecs[i].islast);
      held_bofs = i_bofs;
      #1;
      check($sformatf("vec%0d_src_ack", i), 64'(src_ack), 64'd1);
      e.retire = i_retire;
      step();
      check($sformatf("vec%0d_dst_rdy", i), 64'(dst_rdy), 64'd1);
      check($sformatf("vec%0d_fetch", i),   64'(o_fetch), 64'(vecs[i].fetch));
      check($sformatf("vec%0d_line", i),    64'(o_line),  64'(vecs[i].line));
      check($sformatf("vec%0d_lofs", i),    64'(o_lofs),  64'(vecs[i].lofs));
      check($sformatf("vec%0d_id", i),      64'(o_id),    64'(vecs[i].id));
      check($sformatf("vec%0d_bofs", i),    64'(o_bofs),  64'(held_bofs));
      check($sformatf("vec%0d_retire", i),  64'(o_retire), 64'(e.retire));
      check($sformatf("vec%0d_islast", i),  64'(o_islast), 64'(vecs[i].islast));
    end

    // Backpressure: held output must not change and nothing is accepted
    dst_ack = 1'b0;
    drive(3'd3, 16'h0080, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_src_ack", 64'(src_ack), 64'd0);
      step();
      check("bp_dst_rdy", 64'(dst_rdy), 64'd1);
      check("bp_line",    64'(o_line),  64'h7FF);
      check("bp_lofs",    64'(o_lofs),  64'd31);
      check("bp_id",      64'(o_id),    64'd2);
    end
    dst_ack = 1'b1;
    #1;
    check("bp_release_ack", 64'(src_ack), 64'd1);
    step();
    check("bp_rel0_id",    64'(o_id),    64'd3);
    check("bp_rel0_line",  64'(o_line),  64'd4);
    check("bp_rel0_fetch", 64'(o_fetch), 64'd1);
    drive(3'd3, 16'h0081, 1'b0);
    #1;
    check("bp_rel1_ack", 64'(src_ack), 64'd1);
    step();
    check("bp_rel1_fetch", 64'(o_fetch), 64'd0);
    check("bp_rel1_lofs",  64'(o_lofs),  64'd1);
    src_rdy = 1'b0;
    step();
    check("drain_dst_rdy", 64'(dst_rdy), 64'd0);

    // Reset while a request is held: it is dropped and the table forgets id 0
    dst_ack = 1'b0;
    drive(3'd0, 16'h0040, 1'b0);
    step();
    src_rdy = 1'b0;
    check("hold_dst_rdy",  64'(dst_rdy), 64'd1);
    check("hold_fetch",    64'(o_fetch), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_dst_rdy", 64'(dst_rdy), 64'd0);
    check("rst_mid_line",    64'(o_line),  64'd0);
    dst_ack = 1'b1;
    drive(3'd0, 16'h0040, 1'b0);
    step();
    src_rdy = 1'b0;
    check("rst_mid_refetch", 64'(o_fetch), 64'd1);

    // Randomized traffic against a queue model of the output register and table
    do_reset();
    q.delete();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_nfetch = 0;
    m_ncoal  = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      check("rnd_dst_rdy", 64'(dst_rdy), 64'(q.size() != 0));
      if (q.size() != 0) begin
        check("rnd_id",     64'(o_id),     64'(q[0].id));
        check("rnd_line",   64'(o_line),   64'(q[0].line));
        check("rnd_lofs",   64'(o_lofs),   64'(q[0].lofs));
        check("rnd_fetch",  64'(o_fetch),  64'(q[0].fetch));
        check("rnd_bofs",   64'(o_bofs),   64'(q[0].bofs));
        check("rnd_flags",  64'({o_retire, o_islast}), 64'({q[0].retire, q[0].islast}));
      end
      src_rdy  = ($urandom_range(0, 3) != 0);
      dst_ack  = ($urandom_range(0, 3) != 0);
      i_id     = 3'($urandom_range(0, 5));
      i_linear = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                               : 16'(($urandom_range(0, 3) * 32) + $urandom_range(0, 31));
      i_islast = ($urandom_range(0, 7) == 0);
      i_retire = 1'($urandom_range(0, 1));
      i_bofs   = 16'($urandom);
      #1;
      exp_ack = src_rdy && ((q.size() == 0) || dst_ack);
      check("rnd_src_ack", 64'(src_ack), 64'(exp_ack));
      if ((q.size() != 0) && dst_ack) void'(q.pop_front());
      if (exp_ack) begin
        lin_line = i_linear / 32;
        e.id     = i_id;
        e.line   = lin_line;
        e.lofs   = 5'(i_linear % 32);
        e.fetch  = !((i_id < 3'(NCFG)) && m_valid[i_id] && (m_line[i_id] == lin_line));
        e.bofs   = i_bofs;
        e.retire = i_retire;
        e.islast = i_islast;
        q.push_back(e);
        if (e.fetch) m_nfetch++; else m_ncoal++;
        if (i_id < 3'(NCFG)) begin
          m_valid[i_id] = !i_islast;
          if (!i_islast) m_line[i_id] = lin_line;
        end
      end
      step();
    end
    src_rdy = 1'b0;
`ifdef ACCUM_FETCH_STAT_EN
    check("stat_n_fetch",    64'(o_n_fetch),    64'(m_nfetch));
    check("stat_n_coalesce", 64'(o_n_coalesce), 64'(m_ncoal));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
